// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states,
// and the request legality helper.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  // Stores only have signed-size encodings; loads also have the unsigned ones.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!we) ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    return ok;
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Sign/zero extension of assembled load data according to funct3.
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [31:0] data,
  output logic [31:0] ext
);

  // Pick the extension mode from the load size/signedness.
  always_comb begin
    ext = data;
    case (func3)
      F3_B:    ext = {{24{data[7]}}, data[7:0]};
      F3_H:    ext = {{16{data[15]}}, data[15:0]};
      F3_BU:   ext = {24'b0, data[7:0]};
      F3_HU:   ext = {16'b0, data[15:0]};
      default: ext = data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one request at a time, issues one aligned beat or
// splits misaligned half/word accesses into ascending byte beats, then returns
// a one-cycle response carrying extended load data or an error flag.
//
// Handshake: a request is taken on a rising edge where req_valid && req_ready;
// req_ready is high only in IDLE and requests offered elsewhere are dropped.
// rsp_valid is a single-cycle pulse; rsp_rdata/rsp_err hold until the next one.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_func3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [2:0]        mem_func3,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e        state, state_next;
  logic              we_q;
  logic [2:0]        func3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              split_q;
  logic [1:0]        last_q;
  logic [1:0]        beat_q;
  logic [31:0]       asm_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic              accept;
  logic              req_legal;
  logic              req_misaligned;
  logic [1:0]        req_last;
  logic              last_beat;
  logic [31:0]       asm_next;
  logic [31:0]       ext_data;
  logic [7:0]        beat_byte;

  assign accept    = (state == ST_IDLE) && req_valid;
  assign req_legal = f3_legal(req_we, req_func3);
  assign last_beat = (beat_q == last_q);
  assign beat_byte = wdata_q[8*beat_q +: 8];

  // Classify the incoming request: misaligned half/word becomes 2 or 4 byte beats.
  always_comb begin
    req_misaligned = 1'b0;
    req_last       = 2'd0;
    case (req_func3)
      F3_H, F3_HU: begin
        req_misaligned = req_addr[0];
        req_last       = req_addr[0] ? 2'd1 : 2'd0;
      end
      F3_W: begin
        req_misaligned = |req_addr[1:0];
        req_last       = (|req_addr[1:0]) ? 2'd3 : 2'd0;
      end
      default: begin
        req_misaligned = 1'b0;
        req_last       = 2'd0;
      end
    endcase
  end

  // Merge this beat's read data into the assembly value (bytes land little-endian).
  always_comb begin
    asm_next = asm_q;
    if (split_q) asm_next[8*beat_q +: 8] = mem_rdata[7:0];
    else         asm_next = mem_rdata;
  end

  lsu_extend u_extend (
    .func3 (func3_q),
    .data  (asm_next),
    .ext   (ext_data)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (req_valid) state_next = req_legal ? ST_ACCESS : ST_RESP;
      ST_ACCESS: if (last_beat) state_next = ST_RESP;
      ST_RESP:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Outputs: strobes only in ACCESS; split beats use byte-sized funct3.
  always_comb begin
    req_ready = (state == ST_IDLE);
    rsp_valid = (state == ST_RESP);
    mem_read  = (state == ST_ACCESS) && !we_q;
    mem_write = (state == ST_ACCESS) && we_q;
    mem_addr  = addr_q + ADDR_W'(beat_q);
    mem_func3 = split_q ? (we_q ? F3_B : F3_BU) : func3_q;
    mem_wdata = split_q ? {24'b0, beat_byte} : wdata_q;
  end

  // Request latch, beat counter, load assembly and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      func3_q <= 3'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      split_q <= 1'b0;
      last_q  <= 2'd0;
      beat_q  <= 2'd0;
      asm_q   <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else if (accept) begin
      we_q    <= req_we;
      func3_q <= req_func3;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      split_q <= req_misaligned;
      last_q  <= req_last;
      beat_q  <= 2'd0;
      asm_q   <= 32'd0;
      if (!req_legal) begin
        rdata_q <= 32'd0;
        err_q   <= 1'b1;
      end
    end else if (state == ST_ACCESS) begin
      beat_q <= beat_q + 2'd1;
      if (!we_q) asm_q <= asm_next;
      if (last_beat) begin
        rdata_q <= we_q ? 32'd0 : ext_data;
        err_q   <= 1'b0;
      end
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a byte-addressed memory model.
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_func3;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_read;
  logic        mem_write;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [2:0]  mem_func3;
  logic [31:0] mem_rdata;

  logic [7:0]  mem [0:255];

  int total;
  int bad;

  // observed beats of the last transaction
  logic        obs_rd [0:7];
  logic        obs_wr [0:7];
  logic [7:0]  obs_addr [0:7];
  logic [2:0]  obs_f3 [0:7];
  logic [7:0]  obs_wd [0:7];
  int          n_obs;
  int          lat;

  load_store_unit #(.ADDR_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_func3 (req_func3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_func3 (mem_func3),
    .mem_rdata (mem_rdata)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 1;
    endcase
  endfunction

  // memory model: combinational read, right-justified and zero-filled
  always_comb begin
    mem_rdata = 32'd0;
    for (int i = 0; i < size_of(mem_func3); i++)
      mem_rdata[8*i +: 8] = mem[8'(mem_addr + 8'(i))];
  end

  // memory model: write commits on the clock edge
  always @(posedge clk) begin
    if (mem_write)
      for (int i = 0; i < size_of(mem_func3); i++)
        mem[8'(mem_addr + 8'(i))] = mem_wdata[8*i +: 8];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // drive one request, log beats until rsp_valid, check handshake around the response
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [7:0] addr,
                         input logic [31:0] wdata, input logic hold);
    logic found;
    @(negedge clk);
    check("ready_before_req", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_func3 = f3;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk);
    found = 1'b0;
    lat   = 0;
    n_obs = 0;
    for (int c = 1; c <= 20 && !found; c++) begin
      @(negedge clk);
      if (hold) begin
        req_we    = ~we;
        req_func3 = 3'd2;
        req_addr  = 8'hAA;
        req_wdata = 32'h0;
      end else begin
        req_valid = 1'b0;
      end
      if (rsp_valid) begin
        found     = 1'b1;
        lat       = c;
        req_valid = 1'b0;
      end else if (n_obs < 8) begin
        obs_rd[n_obs]   = mem_read;
        obs_wr[n_obs]   = mem_write;
        obs_addr[n_obs] = mem_addr;
        obs_f3[n_obs]   = mem_func3;
        obs_wd[n_obs]   = mem_wdata[7:0];
        n_obs++;
      end
    end
    req_valid = 1'b0;
    check("rsp_seen", {31'b0, found}, 32'd1);
    if (found) begin
      check("ready_in_resp", {31'b0, req_ready}, 32'd0);
      @(negedge clk);
      check("rsp_one_cycle", {31'b0, rsp_valid}, 32'd0);
      check("ready_after_resp", {31'b0, req_ready}, 32'd1);
    end
  endtask

  task automatic check_beat(input string tag, input int i, input logic rd, input logic wr,
                            input logic [7:0] a, input logic [2:0] f3);
    check({tag, "_rd"}, {31'b0, obs_rd[i]}, {31'b0, rd});
    check({tag, "_wr"}, {31'b0, obs_wr[i]}, {31'b0, wr});
    check({tag, "_addr"}, {24'b0, obs_addr[i]}, {24'b0, a});
    check({tag, "_f3"}, {29'b0, obs_f3[i]}, {29'b0, f3});
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_func3 = 3'd0;
    req_addr  = 8'd0;
    req_wdata = 32'd0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h04] = 8'h09;
    mem[8'h10] = 8'h80;
    mem[8'hFF] = 8'h34;
    mem[8'h00] = 8'h92;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_strobes", {30'b0, mem_read, mem_write}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // lw aligned
    run_req(1'b0, 3'd2, 8'h04, 32'd0, 1'b0);
    check("lw_lat", lat, 2);
    check("lw_beats", n_obs, 1);
    check_beat("lw_b0", 0, 1'b1, 1'b0, 8'h04, 3'd2);
    check("lw_rdata", rsp_rdata, 32'h00000009);
    check("lw_err", {31'b0, rsp_err}, 32'd0);

    // lb sign-extended, then response data held while idle
    run_req(1'b0, 3'd0, 8'h10, 32'd0, 1'b0);
    check("lb_lat", lat, 2);
    check_beat("lb_b0", 0, 1'b1, 1'b0, 8'h10, 3'd0);
    check("lb_rdata", rsp_rdata, 32'hFFFFFF80);
    repeat (3) @(negedge clk);
    check("lb_rdata_hold", rsp_rdata, 32'hFFFFFF80);

    // lbu zero-extended
    run_req(1'b0, 3'd4, 8'h10, 32'd0, 1'b0);
    check("lbu_lat", lat, 2);
    check("lbu_rdata", rsp_rdata, 32'h00000080);

    // lh misaligned across the address wrap
    run_req(1'b0, 3'd1, 8'hFF, 32'd0, 1'b0);
    check("lh_wrap_lat", lat, 3);
    check("lh_wrap_beats", n_obs, 2);
    check_beat("lh_wrap_b0", 0, 1'b1, 1'b0, 8'hFF, 3'd4);
    check_beat("lh_wrap_b1", 1, 1'b1, 1'b0, 8'h00, 3'd4);
    check("lh_wrap_rdata", rsp_rdata, 32'hFFFF9234);

    // sw misaligned, with req_valid held high (must be ignored)
    run_req(1'b1, 3'd2, 8'h0D, 32'hA1B2C3D4, 1'b1);
    check("sw_lat", lat, 5);
    check("sw_beats", n_obs, 4);
    check_beat("sw_b0", 0, 1'b0, 1'b1, 8'h0D, 3'd0);
    check_beat("sw_b1", 1, 1'b0, 1'b1, 8'h0E, 3'd0);
    check_beat("sw_b2", 2, 1'b0, 1'b1, 8'h0F, 3'd0);
    check_beat("sw_b3", 3, 1'b0, 1'b1, 8'h10, 3'd0);
    check("sw_wd0", {24'b0, obs_wd[0]}, 32'hD4);
    check("sw_wd1", {24'b0, obs_wd[1]}, 32'hC3);
    check("sw_wd2", {24'b0, obs_wd[2]}, 32'hB2);
    check("sw_wd3", {24'b0, obs_wd[3]}, 32'hA1);
    check("sw_rdata", rsp_rdata, 32'd0);
    check("sw_err", {31'b0, rsp_err}, 32'd0);
    check("sw_mem", {mem[8'h10], mem[8'h0F], mem[8'h0E], mem[8'h0D]}, 32'hA1B2C3D4);
    check("sw_mem_next", {24'b0, mem[8'h11]}, 32'd0);

    // lw misaligned reads the stored word back
    run_req(1'b0, 3'd2, 8'h0D, 32'd0, 1'b0);
    check("lw_mis_lat", lat, 5);
    check("lw_mis_beats", n_obs, 4);
    check_beat("lw_mis_b3", 3, 1'b1, 1'b0, 8'h10, 3'd4);
    check("lw_mis_rdata", rsp_rdata, 32'hA1B2C3D4);

    // lh aligned, negative half
    run_req(1'b0, 3'd1, 8'h0E, 32'd0, 1'b0);
    check("lh_al_lat", lat, 2);
    check_beat("lh_al_b0", 0, 1'b1, 1'b0, 8'h0E, 3'd1);
    check("lh_al_rdata", rsp_rdata, 32'hFFFFB2C3);

    // lhu misaligned
    run_req(1'b0, 3'd5, 8'h0F, 32'd0, 1'b0);
    check("lhu_mis_lat", lat, 3);
    check("lhu_mis_rdata", rsp_rdata, 32'h0000A1B2);

    // illegal load funct3
    run_req(1'b0, 3'd3, 8'h04, 32'd0, 1'b0);
    check("ld_ill_lat", lat, 1);
    check("ld_ill_beats", n_obs, 0);
    check("ld_ill_err", {31'b0, rsp_err}, 32'd1);
    check("ld_ill_rdata", rsp_rdata, 32'd0);

    // illegal store funct3 (unsigned encoding)
    run_req(1'b1, 3'd4, 8'h30, 32'hFFFFFFFF, 1'b0);
    check("st_ill_lat", lat, 1);
    check("st_ill_beats", n_obs, 0);
    check("st_ill_err", {31'b0, rsp_err}, 32'd1);
    check("st_ill_mem", {24'b0, mem[8'h30]}, 32'd0);

    // sb clears the error flag
    run_req(1'b1, 3'd0, 8'h20, 32'h1234565A, 1'b0);
    check("sb_lat", lat, 2);
    check("sb_err", {31'b0, rsp_err}, 32'd0);
    check("sb_mem", {mem[8'h21], mem[8'h20]}, 32'h005A);

    // reset during the second beat of a split store
    mem[8'h0D] = 8'h00;
    mem[8'h0E] = 8'h00;
    mem[8'h0F] = 8'h00;
    mem[8'h10] = 8'h00;
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_func3 = 3'd2;
    req_addr  = 8'h0D;
    req_wdata = 32'hA1B2C3D4;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_st_b0_addr", {24'b0, mem_addr}, 32'h0D);
    @(negedge clk);
    check("rst_st_b1_addr", {24'b0, mem_addr}, 32'h0E);
    check("rst_st_b1_wr", {31'b0, mem_write}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_st_wr_drop", {31'b0, mem_write}, 32'd0);
    check("rst_st_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    check("rst_st_mem", {mem[8'h10], mem[8'h0F], mem[8'h0E], mem[8'h0D]}, 32'h000000D4);
    begin
      int seen_rsp;
      seen_rsp = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (rsp_valid) seen_rsp++;
      end
      check("rst_st_no_rsp", seen_rsp, 0);
    end
    check("rst_st_ready_after", {31'b0, req_ready}, 32'd1);
    check("rst_st_mem_after", {mem[8'h10], mem[8'h0F], mem[8'h0E], mem[8'h0D]}, 32'h000000D4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
